memory_interface: RTL and testbench

Bridges the microprogrammed controller and datapath to a variable-latency word memory. It sits directly downstream of the controller. It consumes the read and write strobes decoded from `bus_controller`, together with the address (MAR) and write data (MDR) from the datapath. It runs a request/acknowledge transaction with the memory and generates the `wait_` input that holds the controller in its memory micro-state until the access completes.

---
 rtl/memory_interface.sv | 142 ++++++++++++++
 tb/tb_memory_interface.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_interface.sv
// memory_interface: request/acknowledge bridge between the microprogrammed
// controller/datapath and a variable-latency word memory.
// Optional feature macro: MEMIF_TIMEOUT_EN (REQ timeout with sticky err).
// Without the macro, REQ waits indefinitely for mem_ack and err is tied low.
module memory_interface #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wait_,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   latch_req;
    logic   ack_ok;
    logic   abort;
    logic   timeout_hit;

    // Controller holds while a strobe is pending in IDLE or the request is open
    assign wait_ = ((state_q == IDLE) & (read | write)) | (state_q == REQ);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle transaction events
    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        ack_ok    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (read | write) begin
                    latch_req = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    ack_ok  = 1'b1;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side request, latched access fields and read return
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            mem_req     <= (state_d == REQ);
            rdata_valid <= (ack_ok | abort) & ~mem_we;
            if (latch_req) begin
                mem_addr  <= addr;
                mem_wdata <= wdata;
                mem_we    <= write & ~read;
            end
            if (ack_ok & ~mem_we) begin
                rdata <= mem_rdata;
            end else if (abort & ~mem_we) begin
                rdata <= '1;
            end
        end
    end

`ifdef MEMIF_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;

    // Abort when this edge would bring the no-ack count up to TIMEOUT
    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // REQ cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (latch_req) begin
                tmo_cnt <= '0;
            end else if ((state_q == REQ) && !mem_ack) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (abort) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    // No timeout hardware: REQ waits for mem_ack forever
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^CNT_W'(TIMEOUT);
`endif

endmodule

// File: tb/tb_memory_interface.sv
// Self-checking bench for memory_interface: directed scenarios plus random
// accesses against a transaction-level model (latency -> cycle expectations).
module tb_memory_interface;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int          TO     = 3;
`ifdef MEMIF_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wait_;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_rdata = '0;
    logic              exp_err   = 1'b0;

    memory_interface #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .wait_      (wait_),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // One complete access: strobe cycle, REQ cycles, DONE cycle.
    // lat = REQ cycle in which memory acks; hold keeps strobes high in DONE.
    task automatic run_access(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] mword,
                              input int lat, input bit hold);
        bit we_exp;
        bit tmo;
        int n_req;
        we_exp = wr & ~rd;
        tmo    = TMO_EN && (lat > TO);
        n_req  = tmo ? TO : lat;
        // strobe cycle in IDLE
        @(negedge clk);
        read = rd; write = wr; addr = a; wdata = d;
        mem_ack = 1'($urandom); mem_rdata = DATA_W'($urandom);
        #1;
        checks++; if (wait_ !== 1'b1) begin fails++; $display("FAIL strobe_wait: got %b exp 1", wait_); end
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL strobe_mem_req: got %b exp 0", mem_req); end
        // request cycles; strobes and bus inputs scrambled to prove they are latched
        for (int i = 1; i <= n_req; i++) begin
            @(negedge clk);
            read = 1'($urandom); write = 1'($urandom);
            addr = ADDR_W'($urandom); wdata = DATA_W'($urandom);
            mem_ack   = (i == lat);
            mem_rdata = (i == lat) ? mword : DATA_W'($urandom);
            #1;
            checks++; if (wait_ !== 1'b1) begin fails++; $display("FAIL req%0d_wait: got %b exp 1", i, wait_); end
            checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL req%0d_mem_req: got %b exp 1", i, mem_req); end
            checks++; if (mem_we !== we_exp) begin fails++; $display("FAIL req%0d_mem_we: got %b exp %b", i, mem_we, we_exp); end
            checks++; if (mem_addr !== a) begin fails++; $display("FAIL req%0d_mem_addr: got %h exp %h", i, mem_addr, a); end
            checks++; if (mem_wdata !== d) begin fails++; $display("FAIL req%0d_mem_wdata: got %h exp %h", i, mem_wdata, d); end
            checks++; if (rdata_valid !== 1'b0) begin fails++; $display("FAIL req%0d_rvalid: got %b exp 0", i, rdata_valid); end
            checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL req%0d_rdata: got %h exp %h", i, rdata, exp_rdata); end
        end
        if (rd) exp_rdata = tmo ? '1 : mword;
        if (tmo) exp_err = 1'b1;
        // DONE cycle
        @(negedge clk);
        read = hold ? rd : 1'b0; write = hold ? wr : 1'b0;
        addr = ADDR_W'($urandom); mem_ack = 1'($urandom); mem_rdata = DATA_W'($urandom);
        #1;
        checks++; if (wait_ !== 1'b0) begin fails++; $display("FAIL done_wait: got %b exp 0", wait_); end
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL done_mem_req: got %b exp 0", mem_req); end
        checks++; if (rdata_valid !== rd) begin fails++; $display("FAIL done_rvalid: got %b exp %b", rdata_valid, rd); end
        checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL done_rdata: got %h exp %h", rdata, exp_rdata); end
        checks++; if (err !== exp_err) begin fails++; $display("FAIL done_err: got %b exp %b", err, exp_err); end
    endtask

    // One quiet IDLE cycle with no strobe
    task automatic idle_cycle();
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        mem_ack = 1'($urandom); mem_rdata = DATA_W'($urandom);
        #1;
        checks++; if (wait_ !== 1'b0) begin fails++; $display("FAIL idle_wait: got %b exp 0", wait_); end
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL idle_mem_req: got %b exp 0", mem_req); end
        checks++; if (rdata_valid !== 1'b0) begin fails++; $display("FAIL idle_rvalid: got %b exp 0", rdata_valid); end
        checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL idle_rdata: got %h exp %h", rdata, exp_rdata); end
        checks++; if (err !== exp_err) begin fails++; $display("FAIL idle_err: got %b exp %b", err, exp_err); end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b exp 0", mem_we); end
        checks++; if (mem_addr !== '0) begin fails++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin fails++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
        checks++; if (rdata !== '0) begin fails++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
        checks++; if (rdata_valid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b exp 0", rdata_valid); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", err); end
        checks++; if (wait_ !== 1'b0) begin fails++; $display("FAIL rst_wait_idle: got %b exp 0", wait_); end
        read = 1'b1;
        #1;
        checks++; if (wait_ !== 1'b1) begin fails++; $display("FAIL rst_wait_strobe: got %b exp 1", wait_); end
        @(negedge clk);
        read = 1'b0; reset = 1'b0;
        exp_rdata = '0; exp_err = 1'b0;
    endtask

    task automatic test_reset_in_req();
        @(negedge clk);
        read = 1'b1; addr = 12'h123; mem_ack = 1'b0;
        @(negedge clk);
        read = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rreq_req1: got %b exp 1", mem_req); end
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        #1;
        checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rreq_req2: got %b exp 1", mem_req); end
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = '0; exp_err = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rreq_after_req: got %b exp 0", mem_req); end
        checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL rreq_rdata: got %h exp %h", rdata, exp_rdata); end
        checks++; if (rdata_valid !== 1'b0) begin fails++; $display("FAIL rreq_rvalid: got %b exp 0", rdata_valid); end
        checks++; if (wait_ !== 1'b0) begin fails++; $display("FAIL rreq_wait: got %b exp 0", wait_); end
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rreq_still_idle: got %b exp 0", mem_req); end
        checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL rreq_rdata2: got %h exp %h", rdata, exp_rdata); end
        mem_ack = 1'b0;
    endtask

    task automatic test_read_min();
        run_access(1'b1, 1'b0, 12'h0A5, 16'h0000, 16'h1234, 1, 1'b0);
        idle_cycle();
    endtask

    task automatic test_write_wait();
        run_access(1'b0, 1'b1, 12'h3FF, 16'hBEEF, 16'h0BAD, 4, 1'b0);
        idle_cycle();
    endtask

    task automatic test_both_strobes();
        run_access(1'b1, 1'b1, 12'h555, 16'h7777, 16'h5A5A, 2, 1'b0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 12'h010, 16'h0001, 16'hC001, 1, 1'b1);
        run_access(1'b1, 1'b0, 12'h020, 16'h0002, 16'hC002, 1, 1'b1);
        run_access(1'b0, 1'b1, 12'h030, 16'h0003, 16'hC003, 2, 1'b0);
        idle_cycle();
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 12'h0F0, 16'h0000, 16'h4321, TO + 2, 1'b0);
        idle_cycle();
        run_access(1'b0, 1'b1, 12'h0F1, 16'h1111, 16'h0000, TO + 1, 1'b0);
        run_access(1'b1, 1'b0, 12'h0F2, 16'h0000, 16'h2468, TO, 1'b0);
        idle_cycle();
    endtask

    task automatic test_random();
        bit rd;
        bit wr;
        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) wr = 1'b1;
            run_access(rd, wr, ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                       int'($urandom_range(1, 6)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_in_req();
        test_read_min();
        test_write_wait();
        test_both_strobes();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
